mc_controller: RTL and testbench

Multi-cycle control unit for the next-generation MIPS core, replacing the single-cycle combinational controller. It sequences each instruction through IF/ID/EXE/MEM/WB states and issues one-cycle write strobes plus held mux selects to the existing datapath (ifu, RegFile, ALU, DM). Instruction- and data-memory latency are parametrised through wait-state counters. It adds three features:
- sticky exception trapping;
- retired-instruction counter;
- identical strobe timing for jal/jr/j as for other instructions.

---
 rtl/mc_controller.sv | 214 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB/EXC)
// with IM/DM wait states, sticky traps and a retired-instruction counter.
module mc_controller #(
    parameter int IM_WAIT = 0,
    parameter int DM_WAIT = 0,
    parameter bit EXC_EN  = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             overflow,
    input  logic             AddressError,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             Mem_to_Reg,
    output logic             RegDst,
    output logic             nPC_sel,
    output logic             J,
    output logic             jal,
    output logic             jr,
    output logic [1:0]       Extop,
    output logic [2:0]       ALUop,
    output logic [2:0]       state,
    output logic             exc,
    output logic [1:0]       exc_code,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_EXC = 3'd5;

    localparam logic [3:0] IM_LAST = 4'(IM_WAIT);
    localparam logic [3:0] DM_LAST = 4'(DM_WAIT);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] ret_q;
    logic             run_q;
    logic             pc_w, ir_w, rg_w, mm_w;
    logic             active, retire;

    logic rtype, i_addu, i_subu, i_add, i_slt, i_jr;
    logic i_ori, i_lui, i_addi, i_lw, i_sw, i_beq, i_j, i_jal, rsvd;

    assign rtype  = (OpCode == 6'b000000);
    assign i_addu = rtype && (func == 6'b100001);
    assign i_subu = rtype && (func == 6'b100011);
    assign i_add  = rtype && (func == 6'b100000);
    assign i_slt  = rtype && (func == 6'b101010);
    assign i_jr   = rtype && (func == 6'b001000);
    assign i_ori  = (OpCode == 6'b001101);
    assign i_lui  = (OpCode == 6'b001111);
    assign i_addi = (OpCode == 6'b001000);
    assign i_lw   = (OpCode == 6'b100011);
    assign i_sw   = (OpCode == 6'b101011);
    assign i_beq  = (OpCode == 6'b000100);
    assign i_j    = (OpCode == 6'b000010);
    assign i_jal  = (OpCode == 6'b000011);
    assign rsvd   = !(i_addu | i_subu | i_add | i_slt | i_jr | i_ori | i_lui
                    | i_addi | i_lw | i_sw | i_beq | i_j | i_jal);

    // The IR is only reloaded in IF, so decode is stable from ID onward
    assign active     = run_q && (state_q != S_IF) && (state_q != S_EXC);
    assign ALUSrc     = active && (i_ori | i_lui | i_addi | i_lw | i_sw);
    assign Mem_to_Reg = active && i_lw;
    assign RegDst     = active && rtype;
    assign nPC_sel    = active && i_beq;
    assign J          = active && (i_j | i_jal);
    assign jal        = active && i_jal;
    assign jr         = active && i_jr;

    always_comb begin
        Extop = 2'b00;
        ALUop = 3'b000;
        if (active) begin
            if (i_lui)
                Extop = 2'b10;
            else if (i_addi | i_lw | i_sw | i_beq)
                Extop = 2'b01;
            unique case (1'b1)
                i_subu, i_beq:  ALUop = 3'b001;
                i_ori:          ALUop = 3'b010;
                i_slt:          ALUop = 3'b011;
                i_add, i_addi:  ALUop = 3'b100;
                default:        ALUop = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        rg_w    = 1'b0;
        mm_w    = 1'b0;
        unique case (state_q)
            S_IF: begin
                if (cnt_q == IM_LAST) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_ID;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ID: begin
                unique case (1'b1)
                    i_j: begin
                        pc_w    = 1'b1;
                        state_d = S_IF;
                    end
                    i_jal: begin
                        pc_w    = 1'b1;
                        rg_w    = 1'b1;
                        state_d = S_IF;
                    end
                    i_jr: begin
                        pc_w    = 1'b1;
                        state_d = S_IF;
                    end
                    rsvd: begin
                        code_d  = 2'b01;
                        state_d = S_EXC;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                if (i_beq) begin
                    pc_w    = zero;
                    state_d = S_IF;
                end else if (i_lw | i_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q == DM_LAST) begin
                    cnt_d = 4'd0;
                    if (EXC_EN && AddressError) begin
                        code_d  = 2'b11;
                        state_d = S_EXC;
                    end else if (i_sw) begin
                        mm_w    = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                if (EXC_EN && overflow && (i_add | i_addi)) begin
                    code_d  = 2'b10;
                    state_d = S_EXC;
                end else begin
                    rg_w    = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXC: state_d = S_EXC;
            default: state_d = S_IF;
        endcase
    end

    // Only IF itself can loop back to IF, so any other source retires
    assign retire = (state_d == S_IF) && (state_q != S_IF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            cnt_q   <= 4'd0;
            code_q  <= 2'b00;
            ret_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                code_q  <= code_d;
                if (retire)
                    ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    // First IF cycle begins on the first edge after reset release
    assign PCWrite  = run_q & pc_w;
    assign IRWrite  = run_q & ir_w;
    assign RegWrite = run_q & rg_w;
    assign MemWrite = run_q & mm_w;
    assign state    = state_q;
    assign exc      = (state_q == S_EXC);
    assign exc_code = code_q;
    assign retired  = ret_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: three differently parameterised controllers driven with
// directed and random instructions, checked against a per-instruction model.
module tb_mc_controller;

    localparam int IMW [3] = '{0, 2, 1};
    localparam int DMW [3] = '{0, 3, 2};
    localparam bit EEN [3] = '{1'b1, 1'b1, 1'b0};
    localparam int CW  [3] = '{32, 32, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rstn = '0;
    logic [2:0][5:0] opc  = '0;
    logic [2:0][5:0] fnc  = '0;
    logic [2:0]      zr   = '0;
    logic [2:0]      ov   = '0;
    logic [2:0]      ae   = '0;

    wire [2:0]      pcw, irw, rgw, mmw, asrc, m2r, rdst, npc, jj, jl, jrr, exc;
    wire [2:0][1:0] ext, ecode;
    wire [2:0][2:0] aop, st;
    wire [31:0]     ret [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [CW[g]-1:0] r;
        mc_controller #(
            .IM_WAIT(IMW[g]), .DM_WAIT(DMW[g]),
            .EXC_EN(EEN[g]), .CNT_W(CW[g])
        ) u_dut (
            .clk(clk), .reset(rstn[g]),
            .OpCode(opc[g]), .func(fnc[g]),
            .zero(zr[g]), .overflow(ov[g]), .AddressError(ae[g]),
            .PCWrite(pcw[g]), .IRWrite(irw[g]),
            .RegWrite(rgw[g]), .MemWrite(mmw[g]),
            .ALUSrc(asrc[g]), .Mem_to_Reg(m2r[g]), .RegDst(rdst[g]),
            .nPC_sel(npc[g]), .J(jj[g]), .jal(jl[g]), .jr(jrr[g]),
            .Extop(ext[g]), .ALUop(aop[g]), .state(st[g]),
            .exc(exc[g]), .exc_code(ecode[g]), .retired(r)
        );
        assign ret[g] = 32'(r);
    end

    int     n_vec = 0;
    int     n_err = 0;
    longint ret_m [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ops: 0 addu 1 subu 2 add 3 slt 4 jr 5 ori 6 lui 7 addi
    //      8 lw 9 sw 10 beq 11 j 12 jal 13 reserved
    function automatic logic [11:0] enc(input int op);
        case (op)
            0:  return {6'b000000, 6'b100001};
            1:  return {6'b000000, 6'b100011};
            2:  return {6'b000000, 6'b100000};
            3:  return {6'b000000, 6'b101010};
            4:  return {6'b000000, 6'b001000};
            5:  return {6'b001101, 6'b000000};
            6:  return {6'b001111, 6'b000000};
            7:  return {6'b001000, 6'b000000};
            8:  return {6'b100011, 6'b000000};
            9:  return {6'b101011, 6'b000000};
            10: return {6'b000100, 6'b000000};
            11: return {6'b000010, 6'b000000};
            12: return {6'b000011, 6'b000000};
            default:
                if ($urandom_range(0, 1) == 1)
                    return {6'b111111, 6'b000000};
                else
                    return {6'b000000, 6'b100100};
        endcase
    endfunction

    function automatic logic [6:0] sel_e(input int op);
        return {op == 11 || op == 12, op == 12, op == 4, op == 10,
                op == 8, op <= 4, op >= 5 && op <= 9};
    endfunction

    function automatic int alu_e(input int op);
        case (op)
            0: return 0;
            1: return 1;
            2: return 4;
            3: return 3;
            5: return 2;
            7: return 4;
            10: return 1;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_e(input int op);
        case (op)
            5: return 0;
            6: return 2;
            7: return 1;
            default: return -1;
        endcase
    endfunction

    function automatic longint mask(input int k);
        return (longint'(1) << CW[k]) - 1;
    endfunction

    task automatic rst_dut(input int k);
        @(negedge clk);
        rstn[k] = 1'b0;
        #1;
        chk("rst_state", 32'(st[k]), 32'd0);
        chk("rst_strobes", 32'({pcw[k], irw[k], rgw[k], mmw[k]}), 32'd0);
        chk("rst_selects", 32'({asrc[k], m2r[k], rdst[k], npc[k], jj[k],
                               jl[k], jrr[k], ext[k], aop[k]}), 32'd0);
        chk("rst_exc", 32'({exc[k], ecode[k]}), 32'd0);
        chk("rst_retired", ret[k], 32'd0);
        @(negedge clk);
        rstn[k] = 1'b1;
        #1;
        chk("rst_idle", 32'({pcw[k], irw[k]}), 32'd0);
        @(negedge clk);
        ret_m[k] = 0;
    endtask

    task automatic run(input int k, input int op, input bit z,
                       input bit o, input bit a);
        int im, dm, lat, cyc, code, n;
        int pcn, irn, rgn, mmn, ir_at, rg_at, mm_at;
        bit mem, rsv, jt, t_a, t_o, trap, rg_e, mm_e;
        logic [6:0]  sel;
        logic [1:0]  ex_s;
        logic [2:0]  al_s, prev;
        logic [11:0] e;
        im = IMW[k];
        dm = DMW[k];
        mem = (op == 8) || (op == 9);
        rsv = (op == 13);
        jt = (op == 4) || (op == 11) || (op == 12);
        t_a = EEN[k] && a && mem;
        t_o = EEN[k] && o && (op == 2 || op == 7);
        trap = rsv || t_a || t_o;
        code = 0;
        if (rsv) begin
            lat = im + 2;
            code = 1;
        end else if (jt) begin
            lat = im + 2;
        end else if (op == 10) begin
            lat = im + 3;
        end else if (mem) begin
            lat = im + dm + 4 + ((op == 8 && !t_a) ? 1 : 0);
            if (t_a) code = 3;
        end else begin
            lat = im + 4;
            if (t_o) code = 2;
        end
        rg_e = !trap && (op <= 3 || (op >= 5 && op <= 8) || op == 12);
        mm_e = !trap && op == 9;
        e = enc(op);
        opc[k] = e[11:6];
        fnc[k] = e[5:0];
        zr[k] = z;
        ov[k] = o;
        ae[k] = a;
        cyc = 0;
        pcn = 0; irn = 0; rgn = 0; mmn = 0;
        ir_at = -1; rg_at = -1; mm_at = -1;
        sel = '0; ex_s = '0; al_s = '0;
        while (cyc < 64) begin
            if (pcw[k]) pcn++;
            if (irw[k]) begin irn++; ir_at = cyc; end
            if (rgw[k]) begin rgn++; rg_at = cyc; end
            if (mmw[k]) begin mmn++; mm_at = cyc; end
            sel = {jj[k], jl[k], jrr[k], npc[k], m2r[k], rdst[k], asrc[k]};
            ex_s = ext[k];
            al_s = aop[k];
            prev = st[k];
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if ((st[k] == 3'd0 && prev != 3'd0) || st[k] == 3'd5) break;
        end
        chk($sformatf("latency op%0d dut%0d", op, k), cyc, lat);
        chk("pcwrite_n", pcn, 1 + int'(jt) + int'(op == 10 && z));
        chk("irwrite_n", irn, 1);
        chk("irwrite_at", ir_at, im);
        chk("regwrite_n", rgn, 32'(rg_e));
        if (rg_e) chk("regwrite_at", rg_at, lat - 1);
        chk("memwrite_n", mmn, 32'(mm_e));
        if (mm_e) chk("memwrite_at", mm_at, lat - 1);
        if (!trap) begin
            chk($sformatf("selects op%0d", op), 32'(sel), 32'(sel_e(op)));
            if (alu_e(op) >= 0) chk("aluop", 32'(al_s), alu_e(op));
            if (ext_e(op) >= 0) chk("extop", 32'(ex_s), ext_e(op));
            ret_m[k]++;
        end
        chk("retired", ret[k], 32'(ret_m[k] & mask(k)));
        chk("exc_code", 32'(ecode[k]), code);
        chk("exc_flag", 32'(exc[k]), 32'(trap));
        if (trap) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                if (pcw[k] | irw[k] | rgw[k] | mmw[k]) n++;
                if (!exc[k] || st[k] != 3'd5) n++;
                @(negedge clk);
            end
            chk("exc_hold", n, 0);
            rst_dut(k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int op, m, g;
        logic [11:0] e;

        rst_dut(0);
        run(0, 0, 0, 0, 0);
        run(0, 1, 0, 0, 0);
        run(0, 5, 0, 0, 0);
        run(0, 6, 0, 0, 0);
        run(0, 7, 0, 0, 0);
        chk("retired_after5", ret[0], 32'd5);
        run(0, 10, 1, 0, 0);
        run(0, 10, 0, 0, 0);
        run(0, 12, 0, 0, 0);
        run(0, 4, 0, 0, 0);
        run(0, 11, 0, 0, 0);
        run(0, 3, 0, 1, 0);
        run(0, 2, 0, 1, 0);
        run(0, 13, 0, 0, 0);
        run(0, 9, 0, 0, 1);
        run(0, 8, 0, 1, 1);

        rst_dut(1);
        run(1, 8, 0, 0, 0);
        run(1, 9, 0, 0, 0);
        e = enc(9);
        opc[1] = e[11:6];
        fnc[1] = e[5:0];
        ae[1] = 1'b0;
        m = 0;
        g = 0;
        while (st[1] != 3'd3 && g < 40) begin
            if (mmw[1]) m++;
            @(negedge clk);
            g++;
        end
        chk("reach_mem", 32'(st[1]), 32'd3);
        if (mmw[1]) m++;
        @(negedge clk);
        #2;
        rstn[1] = 1'b0;
        #1;
        chk("midmem_state", 32'(st[1]), 32'd0);
        chk("midmem_memwrite", 32'(mmw[1]), 32'd0);
        chk("midmem_retired", ret[1], 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mmw[1]) m++;
        end
        chk("midmem_nopulse", m, 0);
        rstn[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ret_m[1] = 0;
        run(1, 0, 0, 0, 0);

        rst_dut(2);
        run(2, 2, 0, 1, 0);
        run(2, 9, 0, 0, 1);
        run(2, 7, 0, 1, 0);
        run(2, 8, 0, 1, 1);

        for (int k = 0; k < 3; k++) begin
            rst_dut(k);
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 19) == 0)
                    op = 13;
                else
                    op = $urandom_range(0, 12);
                run(k, op, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
